// File: rtl/core_pkg.sv
// Shared constants and the write-back bundle type used by the EX/WB and decode stages.
package core_pkg;

    localparam int DATA_W = 8;
    localparam int REG_AW = 3;
    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [REG_AW-1:0] rd;
        logic              we;
    } wb_bundle;

endpackage

// File: rtl/reg_file.sv
// Register file: two combinational read ports with write-through bypass, one
// synchronous write port, entry 0 hardwired to zero, reset clears every entry.
module reg_file
    import core_pkg::*;
#(
    parameter int DATA_W_P = core_pkg::DATA_W,
    parameter int REG_AW_P = core_pkg::REG_AW
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [REG_AW_P-1:0] wr_addr,
    input  logic [DATA_W_P-1:0] wr_data,
    input  logic [REG_AW_P-1:0] rd_addr_a,
    input  logic [REG_AW_P-1:0] rd_addr_b,
    output logic [DATA_W_P-1:0] rd_data_a,
    output logic [DATA_W_P-1:0] rd_data_b
);

    localparam int DEPTH = 2 ** REG_AW_P;

    logic [DATA_W_P-1:0] mem_reg [DEPTH];
    logic                write_en;
    logic [REG_AW_P-1:0] rd_addr [2];
    logic [DATA_W_P-1:0] rd_data [2];

    assign write_en = we && (wr_addr != REG_AW_P'(0));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (write_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
    end

    assign rd_addr[0] = rd_addr_a;
    assign rd_addr[1] = rd_addr_b;

    // Each read port returns the word being written this cycle, so a consumer
    // never observes stale data for a register that is in the middle of a commit.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
            always_comb begin
                rd_data[gi] = mem_reg[rd_addr[gi]];
                if (rd_addr[gi] == REG_AW_P'(0)) begin
                    rd_data[gi] = '0;
                end else if (write_en && (rd_addr[gi] == wr_addr)) begin
                    rd_data[gi] = wr_data;
                end
            end
        end
    endgenerate

    assign rd_data_a = rd_data[0];
    assign rd_data_b = rd_data[1];

endmodule

// File: rtl/ex_wb_stage.sv
// EX/WB pipeline register, register-file write port and operand-A forwarding
// back into the execute-stage ALU.
module ex_wb_stage
    import core_pkg::*;
#(
    parameter int DATA_W_P = core_pkg::DATA_W,
    parameter int REG_AW_P = core_pkg::REG_AW
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_W_P-1:0] ex_result,
    input  logic [REG_AW_P-1:0] ex_rd,
    input  logic                ex_regwrite,
    input  logic [REG_AW_P-1:0] ex_rs1,
    input  logic                stall,
    input  logic                flush,
    input  logic [REG_AW_P-1:0] rd_addr_a,
    input  logic [REG_AW_P-1:0] rd_addr_b,
    output logic [DATA_W_P-1:0] rd_data_a,
    output logic [DATA_W_P-1:0] rd_data_b,
    output logic [DATA_W_P-1:0] wb_result,
    output logic [REG_AW_P-1:0] wb_rd,
    output logic                wb_we,
    output logic                forward_signal,
    output logic [DATA_W_P-1:0] forward_a
);

    logic [DATA_W_P-1:0] wb_result_reg;
    logic [REG_AW_P-1:0] wb_rd_reg;
    logic                wb_we_reg;

    // A bubble only clears the write enable; result and destination are left
    // untouched so the datapath does not toggle needlessly.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_result_reg <= '0;
            wb_rd_reg     <= '0;
            wb_we_reg     <= 1'b0;
        end else if (flush) begin
            wb_we_reg     <= 1'b0;
        end else if (!stall) begin
            wb_result_reg <= ex_result;
            wb_rd_reg     <= ex_rd;
            wb_we_reg     <= ex_regwrite;
        end
    end

    assign wb_result = wb_result_reg;
    assign wb_rd     = wb_rd_reg;
    assign wb_we     = wb_we_reg;

    reg_file #(
        .DATA_W_P (DATA_W_P),
        .REG_AW_P (REG_AW_P)
    ) u_reg_file (
        .clk       (clk),
        .reset     (reset),
        .we        (wb_we_reg),
        .wr_addr   (wb_rd_reg),
        .wr_data   (wb_result_reg),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b)
    );

    always_comb begin
        forward_signal = wb_we_reg && (wb_rd_reg != REG_AW_P'(REG_ZERO))
                         && (wb_rd_reg == ex_rs1);
        forward_a      = forward_signal ? wb_result_reg : '0;
    end

endmodule

// File: doc/ex_wb_stage.md
Name: ex_wb_stage

Overview:
- Pipeline stage directly downstream of the execute-stage ALU, in the 4-stage core.
- Captures the ALU result with its destination register into the EX/WB pipeline register.
- Owns the 8-entry register file and its single write port.
- Generates the operand-A forwarding pair (forward_signal, forward_a) that feeds back into the ALU's ForwardSignal/ForwardA inputs.

Parameters:
- DATA_W, 8, datapath width (matches ALU result width).
- REG_AW, 3, register-address width; register file depth is 2**REG_AW.

Ports:
- clk  input  1  single core clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- ex_result  input  DATA_W  ALU result from the execute stage.
- ex_rd  input  REG_AW  destination register of the instruction in EX.
- ex_regwrite  input  1  instruction in EX writes ex_rd.
- ex_rs1  input  REG_AW  operand-A source register of the instruction currently in EX (forwarding compare).
- stall  input  1  hold the EX/WB register.
- flush  input  1  load a bubble into the EX/WB register.
- rd_addr_a  input  REG_AW  register-file read port A address (decode stage).
- rd_addr_b  input  REG_AW  register-file read port B address.
- rd_data_a  output  DATA_W  read port A data.
- rd_data_b  output  DATA_W  read port B data.
- wb_result  output  DATA_W  registered result.
- wb_rd  output  REG_AW  registered destination.
- wb_we  output  1  registered write enable.
- forward_signal  output  1  to ALU ForwardSignal.
- forward_a  output  DATA_W  to ALU ForwardA.

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high.
- Reset, sampled high on a rising edge:
  - wb_result=0, wb_rd=0, wb_we=0.
  - All register-file entries = 0.
  - forward_signal therefore resolves to 0 and forward_a to 0.
  - Reset mid-operation discards the in-flight instruction; its write does not occur.
- EX/WB register, priority reset > flush > stall > load:
  - flush: wb_we=0 (bubble); wb_result and wb_rd hold.
  - stall (no flush): all wb_* hold.
  - Otherwise: wb_result<=ex_result, wb_rd<=ex_rd, wb_we<=ex_regwrite.
  - Latency: 1 cycle from EX inputs to wb_* outputs.
- Register-file write:
  - On each rising edge, if wb_we=1 and wb_rd!=0 and reset=0, then regfile[wb_rd]<=wb_result.
  - The write happens whether or not stall is asserted. A held instruction rewrites the same value, which is idempotent.
  - An instruction sampled in EX at edge N is committed at edge N+1.
- Register 0:
  - Reads always return 0.
  - Writes are dropped.
  - Never forwarded.
- Read ports:
  - Combinational.
  - Write-through bypass: if wb_we=1, wb_rd!=0 and rd_addr==wb_rd, rd_data=wb_result; otherwise rd_data=regfile[rd_addr].
  - Ports A and B are independent; both may bypass in the same cycle.
- Forwarding:
  - Combinational: forward_signal = wb_we && (wb_rd!=0) && (wb_rd==ex_rs1).
  - forward_a = wb_result whenever forward_signal=1, else 0.
  - Covers back-to-back dependent instructions; the ALU selects ForwardA+B when forward_signal=1.
- Simultaneous events:
  - flush and stall together: flush wins.
  - Write and read of the same register in the same cycle: the bypass value is returned (new data).

Decomposition:
- Shared package `core_pkg` holds:
  - DATA_W and REG_AW constants.
  - REG_ZERO constant (0).
  - A `wb_bundle` typedef {result, rd, we}, reused by the decode stage.
- One natural sub-module: `reg_file` (2 async read ports, 1 sync write port, x0 hardwired, reset clears all entries), instantiated once here.
- Forwarding compare and pipeline register stay in ex_wb_stage.

Test Plan:
- Reset clear: write R3=0x5A, then assert reset for 1 cycle -> next cycle wb_we=0, forward_signal=0, reading R3 returns 0x00.
- Basic commit: cycle0 ex_result=0x2C, ex_rd=5, ex_regwrite=1 -> cycle1 wb_result=0x2C, wb_we=1, and rd_data_a(addr 5)=0x2C via bypass -> cycle2 regfile[5]=0x2C, read without bypass returns 0x2C.
- Forwarding: cycle0 writes R2=0x10; cycle1 ex_rs1=2 -> forward_signal=1, forward_a=0x10. Repeat with ex_rs1=3 -> forward_signal=0, forward_a=0x00.
- R0 protection: ex_rd=0, ex_regwrite=1, ex_result=0xFF, ex_rs1=0 -> forward_signal=0, rd_data_a(addr 0)=0x00 on every cycle.
- Stall/flush priority: load R4=0x33, then assert stall -> wb_* hold for 3 cycles. Assert stall+flush together -> wb_we=0 next cycle, R4 stays 0x33, and no further write occurs.
- Dual-port bypass: wb_rd=6, wb_we=1, wb_result=0x81, rd_addr_a=6, rd_addr_b=6 -> rd_data_a=rd_data_b=0x81 in the same cycle.
